// File: rtl/dff_bank_arbiter_pkg.sv
// Shared definitions for the shared-register write arbiter: FSM encoding,
// requester count, pointer width and a one-hot decode helper.
package dff_bank_arbiter_pkg;

    localparam int unsigned ARB_NREQ = 4;
    localparam int unsigned PTR_W    = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ACK   = 2'd2
    } state_t;

    function automatic logic [ARB_NREQ-1:0] onehot(input logic [PTR_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/dff_bank_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// wrapping from the top requester back to requester 0.
module rr_pick
    import dff_bank_arbiter_pkg::*;
(
    input  logic [ARB_NREQ-1:0] req,
    input  logic [PTR_W-1:0]    ptr,
    output logic [PTR_W-1:0]    sel,
    output logic                valid
);

    always_comb begin
        sel   = ptr;
        valid = 1'b0;
        // 2-bit index arithmetic gives the 3->0 wrap for free
        for (int unsigned i = 0; i < ARB_NREQ; i++) begin
            if (!valid && req[ptr + PTR_W'(i)]) begin
                sel   = ptr + PTR_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter granting four requesters write access to one shared
// register. Optional macro DFF_ARB_LOCK_EN adds per-requester burst lock.
module dff_bank_arbiter
    import dff_bank_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREQ  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
`ifdef DFF_ARB_LOCK_EN
    input  logic [NREQ-1:0]       lock,
`endif
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       ack,
    output logic [WIDTH-1:0]      q,
    output logic                  busy
);

    state_t            state, state_nxt;
    logic [PTR_W-1:0]  ptr, ptr_nxt;
    logic [PTR_W-1:0]  sel, sel_nxt;
    logic [PTR_W-1:0]  pick_sel;
    logic              pick_valid;
    logic [NREQ-1:0]   gnt_nxt, ack_nxt;
    logic              q_load;

    rr_pick u_pick (
        .req   (req),
        .ptr   (ptr),
        .sel   (pick_sel),
        .valid (pick_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            ptr   <= '0;
            sel   <= '0;
            gnt   <= '0;
            ack   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            sel   <= sel_nxt;
            gnt   <= gnt_nxt;
            ack   <= ack_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (q_load) begin
            q <= wdata[sel*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        ptr_nxt   = ptr;
        q_load    = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_nxt = GRANT;
                    sel_nxt   = pick_sel;
                end
            end
            GRANT: begin
                if (req[sel]) begin
                    q_load    = 1'b1;
                    state_nxt = ACK;
                end else begin
                    state_nxt = IDLE;
                    ptr_nxt   = sel + 2'd1;
                end
            end
            ACK: begin
`ifdef DFF_ARB_LOCK_EN
                // locked burst: re-grant same requester, pointer held
                if (lock[sel] && req[sel]) begin
                    state_nxt = GRANT;
                end else begin
                    state_nxt = IDLE;
                    ptr_nxt   = sel + 2'd1;
                end
`else
                state_nxt = IDLE;
                ptr_nxt   = sel + 2'd1;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt_nxt = '0;
        ack_nxt = '0;
        busy    = (state != IDLE);
        if (state_nxt == GRANT) gnt_nxt = onehot(sel_nxt);
        if (state_nxt == ACK)   ack_nxt = onehot(sel_nxt);
    end

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Self-checking bench for dff_bank_arbiter: transaction-level reference model
// compared every cycle, plus hand-computed directed expectations.
module tb_dff_bank_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] wdata = '0;
`ifdef DFF_ARB_LOCK_EN
    logic [3:0]  lock = '0;
`endif
    logic [3:0]  gnt, ack;
    logic [7:0]  q;
    logic        busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dff_bank_arbiter #(.WIDTH(8), .NREQ(4)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .wdata (wdata),
`ifdef DFF_ARB_LOCK_EN
        .lock  (lock),
`endif
        .gnt   (gnt),
        .ack   (ack),
        .q     (q),
        .busy  (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: owner = requester holding the bus, phase 0 free,
    // 1 granted, 2 written.
    int         m_owner = 0;
    int         m_phase = 0;
    int         m_ptr   = 0;
    logic [7:0] m_q     = '0;

    function automatic int first_from(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_owner <= 0;
            m_phase <= 0;
            m_ptr   <= 0;
            m_q     <= '0;
        end else if (m_phase == 0) begin
            if (first_from(req, m_ptr) >= 0) begin
                m_owner <= first_from(req, m_ptr);
                m_phase <= 1;
            end
        end else if (m_phase == 1) begin
            if (req[m_owner]) begin
                m_q     <= wdata[m_owner*8 +: 8];
                m_phase <= 2;
            end else begin
                m_ptr   <= (m_owner + 1) % 4;
                m_phase <= 0;
            end
        end else begin
`ifdef DFF_ARB_LOCK_EN
            if (lock[m_owner] && req[m_owner]) m_phase <= 1;
            else begin
                m_ptr   <= (m_owner + 1) % 4;
                m_phase <= 0;
            end
`else
            m_ptr   <= (m_owner + 1) % 4;
            m_phase <= 0;
`endif
        end
    end

    always @(negedge clk) begin
        check("model_gnt", 32'(gnt), (m_phase == 1) ? (32'd1 << m_owner) : 32'd0);
        check("model_ack", 32'(ack), (m_phase == 2) ? (32'd1 << m_owner) : 32'd0);
        check("model_q", 32'(q), 32'(m_q));
        check("model_busy", 32'(busy), 32'(m_phase != 0));
        check("exclusive", 32'(((gnt & (gnt - 4'd1)) == 0) && ((ack & (ack - 4'd1)) == 0)
                               && ((gnt & ack) == 0)), 32'd1);
    end

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((req != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
            for (int i = 0; i < 4; i++) if (ack[i]) req[i] = 1'b0;
        end
        check(name, 32'(n < budget), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int order[$];
        int n;
        int n0;
        int prev;
        logic [3:0]  pat_req[3];
        logic [31:0] pat_dat[3];

        // reset held low for 4 time units
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_q", 32'(q), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        #2;
        check("rst_q_late", 32'(q), 32'd0);
        #1 reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("q_after_rst", 32'(q), 32'd0);
        end

        // single write by requester 1
        wdata = 32'h0000_A500;
        req   = 4'b0010;
        @(negedge clk);
        check("single_gnt", 32'(gnt), 32'h2);
        check("single_q_pre", 32'(q), 32'd0);
        @(negedge clk);
        check("single_ack", 32'(ack), 32'h2);
        check("single_q", 32'(q), 32'hA5);
        check("single_gnt_low", 32'(gnt), 32'd0);
        req = 4'b0000;
        @(negedge clk);
        check("single_busy", 32'(busy), 32'd0);
        check("single_ack_low", 32'(ack), 32'd0);

        // all four requesting from ptr=0
        reset = 1'b0;
        #2 reset = 1'b1;
        @(negedge clk);
        wdata = 32'h4433_2211;
        req   = 4'b1111;
        n = 0;
        while (req != 0 && n < 40) begin
            @(negedge clk);
            n++;
            for (int i = 0; i < 4; i++)
                if (ack[i]) begin
                    order.push_back(i);
                    req[i] = 1'b0;
                end
        end
        check("rr_timeout", 32'(n < 40), 32'd1);
        check("rr_count", 32'(order.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check("rr_order", (i < order.size()) ? 32'(order[i]) : 32'd99, 32'(i));
        @(negedge clk);
        check("rr_q_final", 32'(q), 32'h44);
        check("rr_busy", 32'(busy), 32'd0);

        // requester 2 withdraws while granted
        wdata = 32'h5ACC_2211;
        req   = 4'b0100;
        @(negedge clk);
        check("abort_gnt", 32'(gnt), 32'h4);
        req = 4'b0000;
        @(negedge clk);
        check("abort_ack", 32'(ack), 32'd0);
        check("abort_q", 32'(q), 32'h44);
        check("abort_busy", 32'(busy), 32'd0);
        req = 4'b1001;
        @(negedge clk);
        check("abort_next_gnt", 32'(gnt), 32'h8);
        @(negedge clk);
        check("abort_next_ack", 32'(ack), 32'h8);
        check("abort_next_q", 32'(q), 32'h5A);
        req[3] = 1'b0;
        drain("abort_drain", 20);
        check("abort_final_q", 32'(q), 32'h11);

        // reset between edges during GRANT
        req = 4'b0010;
        @(negedge clk);
        check("midrst_gnt", 32'(gnt), 32'h2);
        #2 reset = 1'b0;
        #1;
        check("midrst_gnt_clr", 32'(gnt), 32'd0);
        check("midrst_ack_clr", 32'(ack), 32'd0);
        check("midrst_q_clr", 32'(q), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        req = 4'b0000;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("midrst_no_ack", 32'(ack), 32'd0);
            check("midrst_q_zero", 32'(q), 32'd0);
        end

`ifdef DFF_ARB_LOCK_EN
        // locked burst by requester 0 while requester 1 waits
        wdata = 32'h0000_B2B1;
        lock  = 4'b0001;
        req   = 4'b0011;
        n  = 0;
        n0 = 0;
        prev = -1;
        while (req != 0 && n < 60) begin
            @(negedge clk);
            n++;
            if (ack[0]) begin
                n0++;
                check("lock_q0", 32'(q), 32'hB1);
                if (prev >= 0) check("lock_gap", 32'(n - prev), 32'd2);
                prev = n;
                if (n0 == 3) begin
                    lock   = 4'b0000;
                    req[0] = 1'b0;
                end
            end
            if (ack[1]) begin
                check("lock_r1_waited", 32'(n0), 32'd3);
                req[1] = 1'b0;
            end
        end
        check("lock_timeout", 32'(n < 60), 32'd1);
        check("lock_bursts", 32'(n0), 32'd3);
        @(negedge clk);
        check("lock_final_q", 32'(q), 32'hB2);
`endif

        // extra directed patterns, checked cycle by cycle by the model
        pat_req[0] = 4'b1010; pat_dat[0] = 32'h1E2D_3C4B;
        pat_req[1] = 4'b0110; pat_dat[1] = 32'h0F77_6655;
        pat_req[2] = 4'b1001; pat_dat[2] = 32'hC3DE_AD81;
        for (int p = 0; p < 3; p++) begin
            wdata = pat_dat[p];
            req   = pat_req[p];
            drain("pattern_drain", 40);
        end
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
